round_robin_arbiter: RTL and testbench
======================================

# round_robin_arbiter

Registered round-robin arbiter that shares one resource among `WIDTH` requesters. It chooses a single winner with lowest-set-bit isolation (the `leave_one_hot` function) applied to a rotating priority mask. The arbiter holds the grant until the winner releases it or a hold timeout expires. It sits between requester blocks (DMA channels, bus masters) and a shared port, and drives that port's select lines.

## Interface
- `WIDTH`, 8: number of requesters, ≥2.
- `MAX_HOLD`, 16: maximum consecutive cycles one grant is held. 0 disables the timeout.
- `IDX_W`, `$clog2(WIDTH)`: width of `grant_idx` (localparam).

- `clk` in 1: single clock, rising-edge.
- `nrst` in 1: reset, asynchronous assert, active-low. Release is synchronous to `clk` by the system.
- `ena` in 1: when low, no new grant is issued. A grant already issued is unaffected.
- `req` in WIDTH: request vector, level-sensitive, one bit per requester.
- `grant` out WIDTH: registered, one-hot or zero.
- `grant_valid` out 1: equals `|grant`.
- `grant_idx` out IDX_W: binary index of the set `grant` bit. Holds its last value when `grant` is 0.
- `timeout` out 1: one-cycle pulse when a grant is revoked by `MAX_HOLD`.
- `busy` out 1: high while the FSM is in GRANT or GAP.

## Operation
- **FSM states:** IDLE, GRANT, GAP. Reset state is IDLE.
- **Reset values:** `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0, `busy`=0, priority pointer `ptr`=WIDTH-1, hold counter=0.
- **Winner selection** (combinational, evaluated in IDLE):
  - `mask` = bits strictly above `ptr`.
  - `hi = leave_one_hot(req & mask)`.
  - `win = hi` if `hi` is non-zero, else `leave_one_hot(req)`.
  - The lowest index above the previous winner therefore wins; the search wraps to bit 0.
- **IDLE → GRANT** when `ena` is high and `req` is non-zero:
  - `grant` ← `win`.
  - `grant_idx` ← its index.
  - `ptr` ← that index.
  - hold counter ← 0.
- **In GRANT:**
  - The hold counter increments every cycle and saturates at `MAX_HOLD`.
  - `req` bits other than the granted one are ignored.
  - Changes to `ena` are ignored.
- **GRANT → GAP** when either:
  - the granted `req` bit is low (release), or
  - `MAX_HOLD` is non-zero, the counter equals `MAX_HOLD`-1 and `req` is still high (revoke).
  - On either transition `grant` ← 0.
  - On revoke only, `timeout` ← 1 for one cycle.
- **GAP → IDLE** unconditionally. GAP provides exactly one bus-turnaround cycle with no grant.
- **Fairness:**
  - `ptr` moves to the winner at each grant, so a revoked requester that keeps requesting goes behind all other pending requesters.
  - Worst-case wait is (WIDTH-1)·(MAX_HOLD+2)+2 cycles when `MAX_HOLD` is non-zero.
- **Async reset mid-grant:** all outputs clear immediately and `ptr` returns to WIDTH-1. Arbitration restarts from bit 0.
- The RTL instantiates or inlines `leave_one_hot` twice. Select/index logic is the only combinational path to the registers.

## Timing
- **Request to grant:** latency is 1 cycle. With `req` sampled non-zero in IDLE at edge N, `grant` is valid after edge N+1.
- **Release:** `req` low at edge M clears `grant` after M+1. The earliest next grant is after M+3 (GAP at M+2, IDLE sample at M+2, grant at M+3).
- **Hold limit:** a grant is held at most `MAX_HOLD` cycles. `timeout` is high in the same cycle `grant` first reads 0.
- **Simultaneous release and timeout:** release takes precedence and `timeout` stays 0.
- **`req` pulses shorter than one cycle** may be missed. Requesters must hold `req` until granted.
- **`ena` low in IDLE:** the FSM stays in IDLE, `busy`=0 and `ptr` is unchanged.
- `busy` is registered and aligns with the state register.

## Test plan
Use WIDTH=4 and MAX_HOLD=8 unless noted.
- **Reset and first grant:** after `nrst` release, `req`=4'b1010 held → `grant`=4'b0010 and `grant_idx`=1 one cycle later. `busy`=1 and `timeout` never pulses.
- **Rotation:** `req`=4'b1111 held constant, with each winner dropping its bit for 1 cycle after 3 grant cycles → grant order 0,1,2,3,0. There is one zero-grant GAP cycle between grants.
- **Wrap-around:** `ptr`=3 (last winner 3) and `req`=4'b1001 → winner 0. Then `req`=4'b1001 again → winner 3.
- **Timeout:** requester 2 holds `req` forever → `grant`=4'b0100 for exactly 8 cycles, then 0 with `timeout`=1 for 1 cycle. With `req`=4'b0101 pending, the next grant is 4'b0001.
- **`ena` gating and reset mid-grant:**
  - `ena`=0 with `req`=4'b0001 → `grant` stays 0 indefinitely.
  - Raising `ena` → grant on the next edge.
  - Dropping `nrst` during the grant → `grant`=0 immediately (asynchronously). After release, `req`=4'b1100 → winner 2.
- **Simultaneous release at timeout:** with MAX_HOLD=3, the winner drops `req` on its 3rd hold cycle → grant clears with `timeout`=0.

Source files
------------

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one registered one-hot grant among WIDTH requesters, rotating priority.
// Latency: request sampled in IDLE at edge N gives a grant after edge N+1; release gives GAP then IDLE.
// Backpressure: requesters hold req until granted; a grant lasts until release or MAX_HOLD revoke.
module round_robin_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     ena,
  input  logic [WIDTH-1:0]         req,
  output logic [WIDTH-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(WIDTH)-1:0] grant_idx,
  output logic                     timeout,
  output logic                     busy
);

  localparam int IDX_W  = $clog2(WIDTH);
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  // Last hold count before a revoke; unused when the timeout is disabled.
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Isolate the lowest set bit of a vector.
  function automatic logic [WIDTH-1:0] leave_one_hot(input logic [WIDTH-1:0] x);
    return x & (~x + WIDTH'(1));
  endfunction

  // Binary index of a one-hot vector (zero for an all-zero input).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [WIDTH-1:0] x);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  state_t             state_q;
  logic [WIDTH-1:0]   grant_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               timeout_q;
  logic               busy_q;

  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   win_d;
  logic [IDX_W-1:0]   win_idx_d;
  logic [HOLD_W-1:0]  hold_d;
  logic               held_req;

  // Winner: lowest requester strictly above the last winner, wrapping to bit 0.
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (i > int'(ptr_q));
    end
    hi        = leave_one_hot(req & mask);
    win_d     = (hi != '0) ? hi : leave_one_hot(req);
    win_idx_d = onehot_to_idx(win_d);
    hold_d    = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
    held_req  = |(req & grant_q);
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= IDX_W'(WIDTH - 1);
      hold_q      <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ena && (req != '0)) begin
            state_q     <= GRANT;
            grant_q     <= win_d;
            grant_idx_q <= win_idx_d;
            ptr_q       <= win_idx_d;
            hold_q      <= '0;
            busy_q      <= 1'b1;
          end
        end
        GRANT: begin
          hold_q <= hold_d;
          if (!held_req) begin
            // Release wins over a coincident revoke, so no timeout pulse here.
            state_q <= GAP;
            grant_q <= '0;
          end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
            state_q   <= GAP;
            grant_q   <= '0;
            timeout_q <= 1'b1;
          end
        end
        GAP: begin
          // One turnaround cycle with no grant before arbitrating again.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = grant_idx_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: main instance WIDTH=4/MAX_HOLD=8, side instance MAX_HOLD=3.
// Stimulus pushes expected grants into a queue; a negedge monitor checks each grant as it appears.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_round_robin_arbiter;

  typedef struct {
    logic [3:0] g;
    logic [1:0] idx;
    int         len;   // expected held cycles, 0 = not checked
    logic       to;    // expected timeout at grant end
    int         gap;   // expected zero cycles before grant, 0 = not checked
  } exp_t;

  logic       clk = 1'b0;
  logic       nrst;
  logic       ena;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       timeout;
  logic       busy;

  logic [3:0] req3;
  logic [3:0] grant3;
  logic       grant_valid3;
  logic [1:0] grant_idx3;
  logic       timeout3;
  logic       busy3;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  round_robin_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut (
    .clk(clk), .nrst(nrst), .ena(ena), .req(req),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .timeout(timeout), .busy(busy)
  );

  round_robin_arbiter #(.WIDTH(4), .MAX_HOLD(3)) dut3 (
    .clk(clk), .nrst(nrst), .ena(ena), .req(req3),
    .grant(grant3), .grant_valid(grant_valid3), .grant_idx(grant_idx3),
    .timeout(timeout3), .busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] idx, input int len,
                      input logic to, input int gap);
    exp_t e;
    e.g = g; e.idx = idx; e.len = len; e.to = to; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Hold request r for k grant cycles, release to rel, then return to IDLE.
  task automatic grant_hold(input logic [3:0] r, input int k, input logic [3:0] rel);
    req = r;
    tick();
    repeat (k - 1) tick();
    req = rel;
    tick();
    tick();
  endtask

  task automatic do_reset();
    req  = '0;
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  // Monitor: grant start, length, end/timeout and gap against the expectation queue.
  logic [3:0] prev_g   = '0;
  int         cur_len  = 0;
  int         gap_cnt  = 0;
  logic       in_grant = 1'b0;
  logic       have_exp = 1'b0;
  exp_t       cur;

  always @(negedge clk) begin
    if (!nrst) begin
      if (in_grant && have_exp && exp_q.size() > 0) void'(exp_q.pop_front());
      in_grant = 1'b0;
      have_exp = 1'b0;
      prev_g   = '0;
      gap_cnt  = 0;
    end else begin
      if (grant != 4'd0 && prev_g == 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(grant), 32'd0);
          have_exp = 1'b0;
        end else begin
          cur      = exp_q[0];
          have_exp = 1'b1;
          chk("grant_vec", 32'(grant), 32'(cur.g));
          chk("grant_idx", 32'(grant_idx), 32'(cur.idx));
          chk("grant_valid", 32'(grant_valid), 32'd1);
          chk("busy_in_grant", 32'(busy), 32'd1);
          if (cur.gap != 0) chk("gap_cycles", 32'(gap_cnt), 32'(cur.gap));
        end
        in_grant = 1'b1;
        cur_len  = 1;
      end else if (grant != 4'd0 && grant == prev_g) begin
        cur_len++;
      end else if (grant != 4'd0) begin
        chk("grant_switch_without_gap", 32'(grant), 32'(prev_g));
      end else if (prev_g != 4'd0) begin
        if (have_exp) begin
          if (cur.len != 0) chk("hold_len", 32'(cur_len), 32'(cur.len));
          chk("timeout_at_end", 32'(timeout), 32'(cur.to));
          void'(exp_q.pop_front());
        end
        have_exp = 1'b0;
        in_grant = 1'b0;
        gap_cnt  = 1;
      end else begin
        gap_cnt++;
        if (timeout) chk("stray_timeout", 32'(timeout), 32'd0);
      end
      prev_g = grant;
    end
  end

  initial begin
    logic [3:0] w;
    nrst = 1'b0;
    ena  = 1'b1;
    req  = '0;
    req3 = '0;
    tick();
    tick();
    // Reset state.
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    nrst = 1'b1;
    tick();

    // First grant after reset, one-cycle latency.
    push(4'b0010, 2'd1, 3, 1'b0, 0);
    req = 4'b1010;
    tick();
    chk("first_grant", 32'(grant), 32'b0010);
    chk("first_idx", 32'(grant_idx), 32'd1);
    chk("first_busy", 32'(busy), 32'd1);
    tick();
    tick();
    req = 4'b0000;
    tick();
    chk("release_busy_in_gap", 32'(busy), 32'd1);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Rotation 0,1,2,3,0 with all requesters active.
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      w = 4'b0001 << (i % 4);
      push(w, 2'(i % 4), 3, 1'b0, (i == 0) ? 0 : 2);
    end
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      w = 4'b0001 << (i % 4);
      tick();
      tick();
      req = (i == 4) ? 4'b0000 : (4'b1111 & ~w);
      tick();
      if (i != 4) req = 4'b1111;
      tick();
      tick();
    end

    // Wrap-around: last winner 3, then 0, then back to 3.
    push(4'b1000, 2'd3, 2, 1'b0, 0);
    grant_hold(4'b1000, 2, 4'b0000);
    push(4'b0001, 2'd0, 2, 1'b0, 2);
    grant_hold(4'b1001, 2, 4'b0000);
    push(4'b1000, 2'd3, 2, 1'b0, 2);
    grant_hold(4'b1001, 2, 4'b0000);

    // Timeout: requester 2 holds forever, requester 0 pending.
    push(4'b0100, 2'd2, 8, 1'b1, 2);
    push(4'b0001, 2'd0, 1, 1'b0, 2);
    req = 4'b0100;
    tick();
    req = 4'b0101;
    repeat (7) tick();
    chk("hold_8th_cycle", 32'(grant), 32'b0100);
    tick();
    chk("revoked_grant", 32'(grant), 32'd0);
    chk("timeout_pulse", 32'(timeout), 32'd1);
    tick();
    chk("timeout_one_cycle", 32'(timeout), 32'd0);
    tick();
    chk("after_timeout_grant", 32'(grant), 32'b0001);
    req = 4'b0000;
    tick();
    tick();
    tick();

    // ena gating, ena ignored mid-grant, async reset mid-grant.
    ena = 1'b0;
    req = 4'b0001;
    repeat (5) tick();
    chk("ena_low_grant", 32'(grant), 32'd0);
    chk("ena_low_busy", 32'(busy), 32'd0);
    push(4'b0001, 2'd0, 0, 1'b0, 0);
    ena = 1'b1;
    tick();
    chk("ena_high_grant", 32'(grant), 32'b0001);
    ena = 1'b0;
    tick();
    tick();
    chk("ena_ignored_in_grant", 32'(grant), 32'b0001);
    #3;
    nrst = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_valid", 32'(grant_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    ena = 1'b1;
    req = 4'b0000;
    tick();
    nrst = 1'b1;
    tick();
    push(4'b0100, 2'd2, 3, 1'b0, 0);
    grant_hold(4'b1100, 3, 4'b0000);
    tick();

    // MAX_HOLD=3: release on the 3rd hold cycle beats the revoke.
    req3 = 4'b0001;
    tick();
    chk("mh3_grant", 32'(grant3), 32'b0001);
    tick();
    tick();
    chk("mh3_third_cycle", 32'(grant3), 32'b0001);
    req3 = 4'b0000;
    tick();
    chk("mh3_release_grant", 32'(grant3), 32'd0);
    chk("mh3_release_no_timeout", 32'(timeout3), 32'd0);
    tick();
    tick();
    // MAX_HOLD=3: held request is revoked after exactly 3 cycles.
    req3 = 4'b0010;
    tick();
    chk("mh3_grant2", 32'(grant_idx3), 32'd1);
    tick();
    tick();
    chk("mh3_held3", 32'(grant3), 32'b0010);
    tick();
    chk("mh3_revoked", 32'(grant3), 32'd0);
    chk("mh3_timeout", 32'(timeout3), 32'd1);
    req3 = 4'b0000;
    tick();
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
